// File: rtl/rename_input_queue.sv
// rename_input_queue
//   Decode-to-rename buffer: a 4-wide-in / 4-wide-out circular FIFO of decoded
//   register-operand records. Absorbs decode bursts, holds instructions while
//   rename stalls, and drops everything on a pipeline flush.
//
// Ports
//   clk        clock, all state on posedge
//   resetn     asynchronous active-low reset
//   flush      synchronous discard of all entries
//   in_valid   enqueue slot mask, slot 0 oldest; only the leading run of 1s counts
//   in_data    slot k at [k*DATA_W +: DATA_W]
//   in_ready   at least four free entries, so a full group always fits
//   out_valid  show-ahead head-slot mask, slot 0 oldest
//   out_data   head records, same packing as in_data (invalid slots read 0)
//   out_ready  rename consumes every valid out slot this cycle
//   count      current occupancy
module rename_input_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 18
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [3:0]                in_valid,
  input  logic [4*DATA_W-1:0]       in_data,
  output logic                      in_ready,
  output logic [3:0]                out_valid,
  output logic [4*DATA_W-1:0]       out_data,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [2:0] n_in;
  logic [2:0] n_enq;
  logic [2:0] n_avail;
  logic [2:0] n_out;
  logic [4:0] avail_mask;
  logic       run;

  // Leading run of ones from slot 0; anything above the first gap is ignored.
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (run && in_valid[k]) begin
        n_in = n_in + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Registered-count readiness only: no combinational path from out_ready.
  assign in_ready = (count_q <= CW'(DEPTH - 4));
  assign n_enq    = in_ready ? n_in : 3'd0;

  assign n_avail    = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];
  assign avail_mask = (5'd1 << n_avail) - 5'd1;
  assign out_valid  = avail_mask[3:0];

  // Rename takes the whole visible group or nothing.
  assign n_out = (out_ready && out_valid[0]) ? n_avail : 3'd0;

  always_comb begin
    wp_d    = wp_q + AW'(n_enq);
    rp_d    = rp_q + AW'(n_out);
    count_d = count_q + CW'(n_enq) - CW'(n_out);
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers alone define what is live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (resetn && !flush && (3'(k) < n_enq)) begin
        mem_q[wp_q + AW'(k)] <= in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Show-ahead read; slots past the occupancy read zero so reset output is clean.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k]) begin
        out_data[k*DATA_W +: DATA_W] = mem_q[rp_q + AW'(k)];
      end
    end
  end

  assign count = count_q;

endmodule
